// File: rtl/time_field_editor.sv
// time_field_editor: holds sec/min/hour for the clock-setting UI.
// Fields load from the running clock on set and step up or down with
// independent wrap-around. A held button auto-repeats after a delay.
module time_field_editor #(
  parameter int HOUR_24       = 1,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [1:0] select,
  input  logic       increment,
  input  logic       decrement,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [4:0] hour_out,
  output logic       pm,
  output logic       step
);

  localparam int MAX_COUNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            fire;
  logic            req_valid;
  logic            prev_valid;
  logic            hold_dir;
  logic [1:0]      hold_sel;
  logic [5:0]      sec_q, min_q;
  logic [4:0]      hr24;

  // Step a 0..59 field by one in either direction, wrapping without carry.
  function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // Step the 0..23 hour field by one in either direction, wrapping.
  function automatic logic [4:0] wrap24(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  assign req_valid = increment ^ decrement;

  // Repeat FSM: decide whether this edge steps and how the hold counter moves.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fire       = 1'b0;
    if (set || !req_valid) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!prev_valid) begin
            fire       = 1'b1;
            cnt_next   = ONE_C;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (increment != hold_dir || select != hold_sel) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (REPEAT_DELAY != 0 && cnt == DELAY_C) begin
            fire       = 1'b1;
            cnt_next   = ONE_C;
            state_next = REPEAT;
          end else if (cnt != '1) begin
            cnt_next = cnt + ONE_C;
          end
        end
        REPEAT: begin
          if (increment != hold_dir || select != hold_sel) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == PERIOD_C) begin
            fire     = 1'b1;
            cnt_next = ONE_C;
          end else begin
            cnt_next = cnt + ONE_C;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter, request history and time fields; load beats stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      prev_valid <= 1'b0;
      hold_dir   <= 1'b0;
      hold_sel   <= 2'd0;
      step       <= 1'b0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hr24       <= 5'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      prev_valid <= req_valid;
      step       <= fire && (select != 2'd0);
      if (state == IDLE && state_next == HOLD) begin
        hold_dir <= increment;
        hold_sel <= select;
      end
      if (set) begin
        sec_q <= (sec_in  > 6'd59) ? 6'd0 : sec_in;
        min_q <= (min_in  > 6'd59) ? 6'd0 : min_in;
        hr24  <= (hour_in > 5'd23) ? 5'd0 : hour_in;
      end else if (fire) begin
        case (select)
          2'd1:    sec_q <= wrap60(sec_q, increment);
          2'd2:    min_q <= wrap60(min_q, increment);
          2'd3:    hr24  <= wrap24(hr24, increment);
          default: ;
        endcase
      end
    end
  end

  // Display mapping of the internal 24-hour register.
  always_comb begin
    if (HOUR_24 != 0)
      hour_out = hr24;
    else if (hr24 == 5'd0 || hr24 == 5'd12)
      hour_out = 5'd12;
    else if (hr24 > 5'd12)
      hour_out = hr24 - 5'd12;
    else
      hour_out = hr24;
  end

  assign pm      = (hr24 >= 5'd12);
  assign sec_out = sec_q;
  assign min_out = min_q;

endmodule

// File: tb/tb_time_field_editor.sv
// Self-checking bench for time_field_editor: a 24-hour and a 12-hour
// instance share stimulus; a directed table, corner sequences and a random
// run are compared against constants and a behavioural reference model.
module tb_time_field_editor;

  localparam int DLY = 4;
  localparam int PER = 2;

  logic       clk;
  logic       reset;
  logic       set;
  logic [5:0] sec_in, min_in;
  logic [4:0] hour_in;
  logic [1:0] select;
  logic       increment, decrement;

  logic [5:0] a_sec, a_min, b_sec, b_min;
  logic [4:0] a_hour, b_hour;
  logic       a_pm, b_pm, a_step, b_step;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_sec, m_min, m_hr;
  bit m_step;
  bit prev_valid, run_active, run_dir;
  int run_sel, run_age;

  typedef struct {
    int set_v, sec_v, min_v, hour_v, sel_v, inc_v, dec_v;
    int e_sec, e_min, e_hr, e_h12, e_pm, e_step;
  } vec_t;

  vec_t vecs[21];

  time_field_editor #(.HOUR_24(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut24 (
    .clk(clk), .reset(reset), .set(set), .sec_in(sec_in), .min_in(min_in),
    .hour_in(hour_in), .select(select), .increment(increment), .decrement(decrement),
    .sec_out(a_sec), .min_out(a_min), .hour_out(a_hour), .pm(a_pm), .step(a_step));

  time_field_editor #(.HOUR_24(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut12 (
    .clk(clk), .reset(reset), .set(set), .sec_in(sec_in), .min_in(min_in),
    .hour_in(hour_in), .select(select), .increment(increment), .decrement(decrement),
    .sec_out(b_sec), .min_out(b_min), .hour_out(b_hour), .pm(b_pm), .step(b_step));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_step = 0;
    prev_valid = 0; run_active = 0; run_dir = 0; run_sel = 0; run_age = 0;
  endtask

  // Steps land on the press edge, then DLY edges later, then every PER edges.
  function automatic bit on_schedule(input int age);
    if (age == 0) return 1;
    if (DLY == 0 || age < DLY) return 0;
    return ((age - DLY) % PER) == 0;
  endfunction

  task automatic model_update();
    bit valid, dir, fire;
    valid = increment ^ decrement;
    dir = increment;
    fire = 0;
    m_step = 0;
    if (set) begin
      m_sec = (sec_in > 59) ? 0 : int'(sec_in);
      m_min = (min_in > 59) ? 0 : int'(min_in);
      m_hr  = (hour_in > 23) ? 0 : int'(hour_in);
      run_active = 0;
    end else begin
      if (!valid) run_active = 0;
      else if (run_active) begin
        if (dir == run_dir && int'(select) == run_sel) begin
          run_age++;
          fire = on_schedule(run_age);
        end else run_active = 0;
      end else if (!prev_valid) begin
        run_active = 1; run_age = 0; run_dir = dir; run_sel = int'(select);
        fire = 1;
      end
      if (fire && select != 0) begin
        m_step = 1;
        case (select)
          2'd1: m_sec = dir ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
          2'd2: m_min = dir ? (m_min + 1) % 60 : (m_min + 59) % 60;
          default: m_hr = dir ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
        endcase
      end
    end
    prev_valid = valid;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
  task automatic apply_stimulus(input int s, input int si, input int mi, input int hi,
                                input int sl, input int inc, input int dec);
    set = s[0]; sec_in = 6'(si); min_in = 6'(mi); hour_in = 5'(hi);
    select = 2'(sl); increment = inc[0]; decrement = dec[0];
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_output(input string tag);
    int h12;
    h12 = (m_hr % 12 == 0) ? 12 : m_hr % 12;
    check({tag, " sec24"},  int'(a_sec),  m_sec);
    check({tag, " min24"},  int'(a_min),  m_min);
    check({tag, " hour24"}, int'(a_hour), m_hr);
    check({tag, " pm24"},   int'(a_pm),   int'(m_hr >= 12));
    check({tag, " step24"}, int'(a_step), int'(m_step));
    check({tag, " sec12"},  int'(b_sec),  m_sec);
    check({tag, " min12"},  int'(b_min),  m_min);
    check({tag, " hour12"}, int'(b_hour), h12);
    check({tag, " pm12"},   int'(b_pm),   int'(m_hr >= 12));
    check({tag, " step12"}, int'(b_step), int'(m_step));
  endtask

  initial begin
    int pulses;
    int r_set, r_sel, r_inc, r_dec;

    vecs[0]  = '{1,59,59,23,0,0,0, 59,59,23,11,1,0};
    vecs[1]  = '{0, 0, 0, 0,1,1,0,  0,59,23,11,1,1};
    vecs[2]  = '{0, 0, 0, 0,1,0,0,  0,59,23,11,1,0};
    vecs[3]  = '{0, 0, 0, 0,2,1,0,  0, 0,23,11,1,1};
    vecs[4]  = '{0, 0, 0, 0,2,0,0,  0, 0,23,11,1,0};
    vecs[5]  = '{0, 0, 0, 0,3,1,0,  0, 0, 0,12,0,1};
    vecs[6]  = '{0, 0, 0, 0,3,0,0,  0, 0, 0,12,0,0};
    vecs[7]  = '{0, 0, 0, 0,1,0,1, 59, 0, 0,12,0,1};
    vecs[8]  = '{0, 0, 0, 0,1,0,0, 59, 0, 0,12,0,0};
    vecs[9]  = '{0, 0, 0, 0,2,0,1, 59,59, 0,12,0,1};
    vecs[10] = '{0, 0, 0, 0,2,0,0, 59,59, 0,12,0,0};
    vecs[11] = '{0, 0, 0, 0,3,0,1, 59,59,23,11,1,1};
    vecs[12] = '{0, 0, 0, 0,3,0,0, 59,59,23,11,1,0};
    vecs[13] = '{1,12,34,30,0,0,0, 12,34, 0,12,0,0};
    vecs[14] = '{1, 5, 6,13,0,0,0,  5, 6,13, 1,1,0};
    vecs[15] = '{1, 1, 2, 3,1,1,0,  1, 2, 3, 3,0,0};
    vecs[16] = '{0, 0, 0, 0,1,1,0,  1, 2, 3, 3,0,0};
    vecs[17] = '{0, 0, 0, 0,1,0,0,  1, 2, 3, 3,0,0};
    vecs[18] = '{0, 0, 0, 0,0,1,0,  1, 2, 3, 3,0,0};
    vecs[19] = '{0, 0, 0, 0,0,0,0,  1, 2, 3, 3,0,0};
    vecs[20] = '{1,60,63, 5,0,0,0,  0, 0, 5, 5,0,0};

    reset = 1'b1; set = 1'b0; sec_in = '0; min_in = '0; hour_in = '0;
    select = '0; increment = 1'b0; decrement = 1'b0;
    model_reset();
    #2;
    check("reset sec",    int'(a_sec),  0);
    check("reset min",    int'(a_min),  0);
    check("reset hour24", int'(a_hour), 0);
    check("reset hour12", int'(b_hour), 12);
    check("reset pm",     int'(a_pm),   0);
    check("reset step",   int'(a_step), 0);
    @(negedge clk);
    reset = 1'b0;

    // directed table
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].set_v, vecs[i].sec_v, vecs[i].min_v, vecs[i].hour_v,
                     vecs[i].sel_v, vecs[i].inc_v, vecs[i].dec_v);
      check($sformatf("vec%0d sec", i),    int'(a_sec),  vecs[i].e_sec);
      check($sformatf("vec%0d min", i),    int'(a_min),  vecs[i].e_min);
      check($sformatf("vec%0d hour24", i), int'(a_hour), vecs[i].e_hr);
      check($sformatf("vec%0d hour12", i), int'(b_hour), vecs[i].e_h12);
      check($sformatf("vec%0d pm", i),     int'(b_pm),   vecs[i].e_pm);
      check($sformatf("vec%0d step", i),   int'(a_step), vecs[i].e_step);
      check($sformatf("vec%0d step12", i), int'(b_step), vecs[i].e_step);
    end

    // auto-repeat: held for 10 edges steps at 0, 4, 6, 8
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check_output("rep load");
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(0, 0, 0, 0, 1, 1, 0);
      check_output($sformatf("rep k%0d", k));
      check($sformatf("rep pulse k%0d", k), int'(a_step),
            int'(k == 0 || k == 4 || k == 6 || k == 8));
      pulses += int'(a_step);
    end
    check("rep sec", int'(a_sec), 4);
    check("rep pulses", pulses, 4);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    check_output("rep release");

    // select change while repeating aborts until release and re-press
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    check("selchg sec before", int'(a_sec), 2);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(0, 0, 0, 0, 2, 1, 0);
      check_output($sformatf("selchg k%0d", k));
      check($sformatf("selchg nostep k%0d", k), int'(a_step), 0);
    end
    apply_stimulus(0, 0, 0, 0, 2, 0, 0);
    apply_stimulus(0, 0, 0, 0, 2, 1, 0);
    check("selchg repress min", int'(a_min), 1);
    check("selchg repress step", int'(a_step), 1);
    apply_stimulus(0, 0, 0, 0, 2, 0, 0);

    // both buttons while repeating: no step
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 0, 0, 1, 1, 1);
      check($sformatf("both nostep k%0d", k), int'(a_step), 0);
      check($sformatf("both sec k%0d", k), int'(a_sec), 2);
    end
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    check_output("both release");

    // set while repeating: load wins, held button does not step afterwards
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    apply_stimulus(1, 7, 8, 9, 1, 1, 0);
    check("setwin sec", int'(a_sec), 7);
    check("setwin hour", int'(a_hour), 9);
    check("setwin step", int'(a_step), 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 0, 0, 1, 1, 0);
      check($sformatf("setwin held k%0d", k), int'(a_step), 0);
    end
    check("setwin sec after", int'(a_sec), 7);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);

    // asynchronous reset mid-hold; held button steps on first edge after release
    apply_stimulus(1, 30, 20, 15, 0, 0, 0);
    for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async sec", int'(a_sec), 0);
    check("async min", int'(a_min), 0);
    check("async hour24", int'(a_hour), 0);
    check("async hour12", int'(b_hour), 12);
    check("async pm", int'(b_pm), 0);
    check("async step", int'(a_step), 0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 1, 1, 0);
    check("async restep sec", int'(a_sec), 1);
    check("async restep step", int'(a_step), 1);
    check_output("async restep");
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    check_output("async release");

    // randomized run against the reference model
    r_sel = 1; r_inc = 0; r_dec = 0;
    for (int n = 0; n < 600; n++) begin
      r_set = ($urandom_range(0, 19) == 0) ? 1 : 0;
      if ($urandom_range(0, 11) == 0) r_sel = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        r_inc = int'($urandom_range(0, 1));
        r_dec = ($urandom_range(0, 3) == 0) ? r_inc : 1 - r_inc;
        if ($urandom_range(0, 4) == 0) begin r_inc = 0; r_dec = 0; end
      end
      apply_stimulus(r_set, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 31)), r_sel, r_inc, r_dec);
      check_output($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
